// File: rtl/ahmes_alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ahmes_alu_pkg
// Brief    : Opcodes, flag record and datapath width shared by the Ahmes ALU.
// Revision : 1.0
// ============================================================================
package ahmes_alu_pkg;

  localparam int WIDTH = 8;

  typedef enum logic [3:0] {
    OP_ADIC = 4'b0001,
    OP_SUB  = 4'b0010,
    OP_OU   = 4'b0011,
    OP_E    = 4'b0100,
    OP_NAO  = 4'b0101,
    OP_DLE  = 4'b0110,
    OP_DLD  = 4'b0111,
    OP_DAE  = 4'b1000,
    OP_DAD  = 4'b1001
  } opcode_e;

  typedef struct packed {
    logic N;
    logic Z;
    logic C;
    logic V;
    logic B;
  } flags_t;

endpackage : ahmes_alu_pkg
`default_nettype wire

// File: rtl/ahmes_alu_shifter.sv
`default_nettype none
// ============================================================================
// Module   : ahmes_alu_shifter
// Brief    : Rotate-through-carry and arithmetic shifts of operand A.
//            Only built when ALU_SHIFT_OPS_EN is defined.
// Revision : 1.0
// ============================================================================
`ifdef ALU_SHIFT_OPS_EN
module ahmes_alu_shifter
  import ahmes_alu_pkg::*;
#(
  parameter int WIDTH = ahmes_alu_pkg::WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic             cin,
  input  logic [1:0]       sel,
  output logic [WIDTH-1:0] res,
  output logic             c,
  output logic             v
);

  localparam logic [1:0] C_SEL_DLE = 2'b00;
  localparam logic [1:0] C_SEL_DLD = 2'b01;
  localparam logic [1:0] C_SEL_DAE = 2'b10;

  always_comb begin
    res = {a[WIDTH-1], a[WIDTH-1:1]};
    c   = a[0];
    v   = 1'b0;
    case (sel)
      C_SEL_DLE: begin
        res = {a[WIDTH-2:0], cin};
        c   = a[WIDTH-1];
      end
      C_SEL_DLD: begin
        res = {cin, a[WIDTH-1:1]};
        c   = a[0];
      end
      C_SEL_DAE: begin
        res = {a[WIDTH-2:0], 1'b0};
        c   = a[WIDTH-1];
        // Sign changes whenever the two top bits differ.
        v   = a[WIDTH-1] ^ a[WIDTH-2];
      end
      default: begin
        res = {a[WIDTH-1], a[WIDTH-1:1]};
        c   = a[0];
      end
    endcase
  end

endmodule : ahmes_alu_shifter
`endif
`default_nettype wire

// File: rtl/ahmes_alu.sv
`default_nettype none
// ============================================================================
// Module   : ahmes_alu
// Brief    : Registered 8-bit ALU for the Ahmes accumulator CPU.
//            ALU_SHIFT_OPS_EN enables the rotate/shift opcodes 0110-1001.
// Revision : 1.0
// ============================================================================
module ahmes_alu
  import ahmes_alu_pkg::*;
#(
  parameter int WIDTH = ahmes_alu_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [3:0]       operacao,
  input  logic [WIDTH-1:0] operA,
  input  logic [WIDTH-1:0] operB,
  input  logic             Cin,
  output logic [WIDTH-1:0] result,
  output logic             N,
  output logic             Z,
  output logic             C,
  output logic             B,
  output logic             V
);

  logic [WIDTH-1:0] w_res;
  logic             w_c;
  logic             w_b;
  logic             w_v;
  flags_t           w_flags;

  logic [WIDTH-1:0] r_result;
  flags_t           r_flags;

`ifdef ALU_SHIFT_OPS_EN
  logic [WIDTH-1:0] w_sh_res;
  logic             w_sh_c;
  logic             w_sh_v;

  // {op[3], op[0]} maps 0110/0111/1000/1001 onto selects 0..3.
  if (1) begin : g_shifter
    ahmes_alu_shifter #(
      .WIDTH (WIDTH)
    ) u_shifter (
      .a   (operA),
      .cin (Cin),
      .sel ({operacao[3], operacao[0]}),
      .res (w_sh_res),
      .c   (w_sh_c),
      .v   (w_sh_v)
    );
  end
`else
  logic w_unused_cin;
  assign w_unused_cin = Cin;
`endif

  always_comb begin
    w_res = operB;
    w_c   = 1'b0;
    w_b   = 1'b0;
    w_v   = 1'b0;
    case (operacao)
      OP_ADIC: begin
        {w_c, w_res} = {1'b0, operA} + {1'b0, operB};
        w_v = (operA[WIDTH-1] == operB[WIDTH-1]) && (w_res[WIDTH-1] != operA[WIDTH-1]);
      end
      OP_SUB: begin
        w_res = operA - operB;
        w_b   = (operA < operB);
        w_v   = (operA[WIDTH-1] != operB[WIDTH-1]) && (w_res[WIDTH-1] != operA[WIDTH-1]);
      end
      OP_OU:  w_res = operA | operB;
      OP_E:   w_res = operA & operB;
      OP_NAO: w_res = ~operA;
`ifdef ALU_SHIFT_OPS_EN
      OP_DLE, OP_DLD, OP_DAE, OP_DAD: begin
        w_res = w_sh_res;
        w_c   = w_sh_c;
        w_v   = w_sh_v;
      end
`endif
      default: w_res = operB;
    endcase
  end

  always_comb begin
    w_flags   = '0;
    w_flags.N = w_res[WIDTH-1];
    w_flags.Z = (w_res == '0);
    w_flags.C = w_c;
    w_flags.V = w_v;
    w_flags.B = w_b;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_result <= '0;
      r_flags  <= '0;
    end else if (en) begin
      r_result <= w_res;
      r_flags  <= w_flags;
    end
  end

  assign result = r_result;
  assign N      = r_flags.N;
  assign Z      = r_flags.Z;
  assign C      = r_flags.C;
  assign B      = r_flags.B;
  assign V      = r_flags.V;

endmodule : ahmes_alu
`default_nettype wire

// File: tb/tb_ahmes_alu.sv
`default_nettype none
// ============================================================================
// Module   : tb_ahmes_alu
// Brief    : Directed scoreboard bench for ahmes_alu (flags packed as NZCVB).
// Revision : 1.0
// ============================================================================
module tb_ahmes_alu;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [3:0] operacao;
  logic [7:0] operA;
  logic [7:0] operB;
  logic       Cin;
  logic [7:0] result;
  logic       N, Z, C, B, V;

  typedef struct {
    logic [7:0] res;
    logic [4:0] fl;
    string      tag;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass;
  int   n_total;

  ahmes_alu #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .operacao (operacao),
    .operA    (operA),
    .operB    (operB),
    .Cin      (Cin),
    .result   (result),
    .N        (N),
    .Z        (Z),
    .C        (C),
    .B        (B),
    .V        (V)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_front();
    exp_t       e;
    logic [4:0] got_fl;
    got_fl = {N, Z, C, V, B};
    n_total++;
    if (exp_q.size() == 0) begin
      $error("FAIL scoreboard_empty: got queue size 0 required at least 1");
    end else begin
      e = exp_q.pop_front();
      assert (result === e.res) n_pass++;
      else $error("FAIL %s_result: got %0d required %0d", e.tag, result, e.res);
      n_total++;
      assert (got_fl === e.fl) n_pass++;
      else $error("FAIL %s_flags: got NZCVB=%b required %b", e.tag, got_fl, e.fl);
    end
  endtask

  task automatic step(input logic r, input logic e, input logic [3:0] op,
                      input logic [7:0] a, input logic [7:0] b, input logic ci,
                      input logic [7:0] xres, input logic [4:0] xfl, input string tag);
    exp_t x;
    rst_n    = r;
    en       = e;
    operacao = op;
    operA    = a;
    operB    = b;
    Cin      = ci;
    x.res = xres;
    x.fl  = xfl;
    x.tag = tag;
    exp_q.push_back(x);
    @(posedge clk);
    #1;
    check_front();
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst_n = 1'b0; en = 1'b1; operacao = 4'd1; operA = 8'd55; operB = 8'd66; Cin = 1'b0;
    @(posedge clk); #1;

    step(1'b0, 1'b1, 4'b0001, 8'd55,  8'd66,  1'b0, 8'd0,   5'b00000, "reset");
    step(1'b1, 1'b0, 4'b0001, 8'd10,  8'd20,  1'b0, 8'd0,   5'b00000, "hold_en0");
    step(1'b1, 1'b1, 4'b0001, 8'd10,  8'd20,  1'b0, 8'd30,  5'b00000, "add_10_20");
    step(1'b1, 1'b1, 4'b0001, 8'd10,  8'd20,  1'b1, 8'd30,  5'b00000, "add_cin_ignored");
    step(1'b1, 1'b1, 4'b0001, 8'd255, 8'd1,   1'b0, 8'd0,   5'b01100, "add_255_1");
    step(1'b1, 1'b1, 4'b0001, 8'd127, 8'd1,   1'b0, 8'd128, 5'b10010, "add_127_1");
    step(1'b1, 1'b1, 4'b0010, 8'd50,  8'd20,  1'b0, 8'd30,  5'b00000, "sub_50_20");
    step(1'b1, 1'b1, 4'b0010, 8'd0,   8'd1,   1'b0, 8'd255, 5'b10001, "sub_0_1");
    step(1'b1, 1'b1, 4'b0010, 8'd128, 8'd1,   1'b0, 8'd127, 5'b00010, "sub_128_1");
    step(1'b1, 1'b1, 4'b0011, 8'd170, 8'd85,  1'b0, 8'd255, 5'b10000, "or");
    step(1'b1, 1'b1, 4'b0100, 8'd240, 8'd15,  1'b0, 8'd0,   5'b01000, "and");
    step(1'b1, 1'b1, 4'b0101, 8'd240, 8'd99,  1'b0, 8'd15,  5'b00000, "not");
    step(1'b1, 1'b1, 4'b0000, 8'd3,   8'd200, 1'b1, 8'd200, 5'b10000, "pass_0000");
`ifdef ALU_SHIFT_OPS_EN
    step(1'b1, 1'b1, 4'b0110, 8'd129, 8'd7,   1'b1, 8'd3,   5'b00100, "dle");
    step(1'b1, 1'b1, 4'b0111, 8'd1,   8'd7,   1'b1, 8'd128, 5'b10100, "dld");
    step(1'b1, 1'b1, 4'b1000, 8'd64,  8'd7,   1'b0, 8'd128, 5'b10010, "dae");
    step(1'b1, 1'b1, 4'b1001, 8'd129, 8'd7,   1'b0, 8'd192, 5'b10100, "dad");
`else
    step(1'b1, 1'b1, 4'b0110, 8'd129, 8'd7,   1'b1, 8'd7,   5'b00000, "dle_pass");
    step(1'b1, 1'b1, 4'b1001, 8'd129, 8'd7,   1'b0, 8'd7,   5'b00000, "dad_pass");
`endif
    step(1'b1, 1'b1, 4'b1111, 8'd77,  8'd0,   1'b0, 8'd0,   5'b01000, "pass_1111");
    step(1'b1, 1'b1, 4'b0010, 8'd5,   8'd9,   1'b0, 8'd252, 5'b10001, "sub_5_9");
    step(1'b1, 1'b0, 4'bxxxx, 8'hxx,  8'hxx,  1'bx, 8'd252, 5'b10001, "hold_x");
    step(1'b1, 1'b0, 4'b0001, 8'd1,   8'd1,   1'b0, 8'd252, 5'b10001, "hold_x2");
    step(1'b0, 1'b1, 4'b0001, 8'd100, 8'd100, 1'b0, 8'd0,   5'b00000, "reset_wins");
    step(1'b1, 1'b1, 4'b0001, 8'd128, 8'd128, 1'b0, 8'd0,   5'b01110, "add_128_128");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_ahmes_alu
`default_nettype wire

// File: doc/ahmes_alu.md
Name: ahmes_alu

Overview:
- 8-bit ALU for the Ahmes accumulator CPU datapath.
- Executes add, subtract, OR, AND, NOT and four shift/rotate ops on operand A (accumulator) and operand B (memory data).
- Produces the result plus N, Z, C, B, V flags for the flag register.
- Result and flags are registered, so there is one clock of latency.

Parameters:
- WIDTH, 8, datapath width. All behaviour below is specified for 8; bit 7 means bit WIDTH-1.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- en  in  1  capture enable. When 1, the registered outputs update on the edge.
- operacao  in  4  opcode.
- operA  in  8  operand A (accumulator).
- operB  in  8  operand B (memory operand).
- Cin  in  1  carry-in, used only by the rotate ops.
- result  out  8  registered result.
- N  out  1  registered negative flag: result[7].
- Z  out  1  registered zero flag: result == 0.
- C  out  1  registered carry flag.
- B  out  1  registered borrow flag.
- V  out  1  registered two's-complement overflow flag.

Behaviour:
- Reset: on a rising clk edge with rst_n = 0, result = 0 and N, Z, C, B, V = 0. Reset wins over en.
- Update: on a rising edge with rst_n = 1 and en = 1, the combinational result and flags of the current inputs are registered. With en = 0 all outputs hold.
- Latency: exactly 1 cycle. No handshake. Back-to-back ops are allowed every cycle.
- N and Z are always derived from the 8-bit result being registered, for every opcode.
- 0001 ADD:
  - {C, res} = A + B (9-bit sum); Cin is ignored.
  - V = (A[7] == B[7]) && (res[7] != A[7]).
  - B = 0.
- 0010 SUB:
  - res = A - B mod 256.
  - B = 1 when A < B (unsigned), else 0.
  - C = 0 always.
  - V = (A[7] != B[7]) && (res[7] != A[7]).
- 0011 OR: res = A | B. C, B, V = 0.
- 0100 AND: res = A & B. C, B, V = 0.
- 0101 NOT: res = ~A; operB is ignored. C, B, V = 0.
- 0110 DLE (rotate left through carry): res = {A[6:0], Cin}, C = A[7]. B, V = 0.
- 0111 DLD (rotate right through carry): res = {Cin, A[7:1]}, C = A[0]. B, V = 0.
- 1000 DAE (arithmetic shift left): res = {A[6:0], 0}, C = A[7], V = A[7] ^ A[6]. B = 0.
- 1001 DAD (arithmetic shift right): res = {A[7], A[7:1]}, C = A[0]. B, V = 0.
- 0000 and 1010-1111 (pass-through): res = B. C, B, V = 0.
- Boundaries:
  - 255 + 1 -> res 0, Z = 1, C = 1.
  - 127 + 1 -> res 128, V = 1, N = 1.
  - 0 - 1 -> res 255, B = 1, N = 1.
  - 128 - 1 -> res 127, V = 1.
  - X on inputs while en = 0 must not disturb the held outputs.

Optional Feature:
- Macro ALU_SHIFT_OPS_EN.
- Defined: opcodes 0110-1001 behave as specified above.
- Undefined: the shift/rotate logic is omitted and opcodes 0110-1001 fall into the pass-through default (res = B, C, B, V = 0). ADD, SUB and the logic ops are unaffected.

Decomposition:
- Package ahmes_alu_pkg holds:
  - the opcode enum: OP_ADIC, OP_SUB, OP_OU, OP_E, OP_NAO, OP_DLE, OP_DLD, OP_DAE, OP_DAD;
  - the packed flags struct {N, Z, C, V, B};
  - the WIDTH constant.
- One sub-module, ahmes_alu_shifter: combinational; takes A, Cin and a 2-bit shift select; returns res, C and V. It is instantiated only under ALU_SHIFT_OPS_EN.
- Opcode decode, arithmetic and the output registers stay in ahmes_alu.

Test Plan:
- Reset and hold: rst_n = 0 for 2 cycles -> result 0, flags 00000. Then en = 0 with ADD 10 + 20 -> outputs stay 0.
- ADD: 10 + 20, Cin 0 -> next cycle result 30, NZCVB = 00000. 255 + 1 -> result 0, Z = 1, C = 1. 127 + 1 -> result 128, N = 1, V = 1.
- SUB: 50 - 20 -> result 30, flags 00000. 0 - 1 -> result 255, N = 1, B = 1, C = 0.
- Logic: OR 170 | 85 -> result 255, N = 1. AND 240 & 15 -> result 0, Z = 1. NOT 240 -> result 15, flags 00000.
- Shifts (macro defined):
  - DLE A = 129, Cin 1 -> result 3, C = 1.
  - DLD A = 1, Cin 1 -> result 128, N = 1, C = 1.
  - DAE A = 64 -> result 128, V = 1.
  - DAD A = 129 -> result 192, N = 1, C = 1.
- Macro undefined: DLE with A = 129, B = 7 -> result 7, C = 0. Opcode 1111 with B = 0 -> result 0, Z = 1.
